// File: rtl/xc_malu_ctrl.sv
// Request sequencer in front of xc_malu: decodes compact opcodes into xc_malu
// controls, holds them across the operation and returns the result in 32-bit beats.
module xc_malu_ctrl #(
  parameter int MAX_BUSY = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [2:0]  req_pw,
  input  logic        req_wide,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic        req_kill,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic        malu_uop_div,
  output logic        malu_uop_rem,
  output logic        malu_uop_mul,
  output logic        malu_uop_madd,
  output logic        malu_uop_msub_1,
  output logic        malu_uop_msub_2,
  output logic        malu_uop_macc_1,
  output logic        malu_uop_macc_2,
  output logic        malu_mod_lh_sign,
  output logic        malu_mod_rh_sign,
  output logic        malu_mod_carryless,
  output logic        malu_pw_32,
  output logic        malu_pw_16,
  output logic        malu_pw_8,
  output logic        malu_pw_4,
  output logic        malu_pw_2,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_hi,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);
  localparam int CW = $clog2(MAX_BUSY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RSP_LO, RSP_HI} state_t;

  state_t        state;
  logic [CW-1:0] busy_cnt;
  logic          wide_q;
  logic [31:0]   res_hi;
  logic          timeout;

  logic [7:0] dec_uop;
  logic       dec_lh;
  logic       dec_rh;
  logic       dec_cl;
  logic [4:0] dec_pw;
  logic       dec_legal;

  // uop bits, msb first: div rem mul madd msub_1 msub_2 macc_1 macc_2; pw bits: 32 16 8 4 2
  always_comb begin
    dec_uop   = '0;
    dec_lh    = 1'b0;
    dec_rh    = 1'b0;
    dec_cl    = 1'b0;
    dec_legal = 1'b1;
    case (req_pw)
      3'd1:    dec_pw = 5'b01000;
      3'd2:    dec_pw = 5'b00100;
      3'd3:    dec_pw = 5'b00010;
      3'd4:    dec_pw = 5'b00001;
      default: dec_pw = 5'b10000;
    endcase
    case (req_op)
      4'd0:  begin dec_uop = 8'b1000_0000; dec_lh = 1'b1; dec_rh = 1'b1; dec_pw = 5'b10000; end
      4'd1:  begin dec_uop = 8'b1000_0000; dec_pw = 5'b10000; end
      4'd2:  begin dec_uop = 8'b0100_0000; dec_lh = 1'b1; dec_rh = 1'b1; dec_pw = 5'b10000; end
      4'd3:  begin dec_uop = 8'b0100_0000; dec_pw = 5'b10000; end
      4'd4:  dec_uop = 8'b0010_0000;
      4'd5:  begin dec_uop = 8'b0010_0000; dec_lh = 1'b1; dec_rh = 1'b1; end
      4'd6:  begin dec_uop = 8'b0010_0000; dec_cl = 1'b1; end
      4'd7:  dec_uop = 8'b0001_0000;
      4'd8:  dec_uop = 8'b0000_1000;
      4'd9:  dec_uop = 8'b0000_0100;
      4'd10: dec_uop = 8'b0000_0010;
      4'd11: dec_uop = 8'b0000_0001;
      default: dec_legal = 1'b0;
    endcase
  end

  assign timeout    = (busy_cnt == CW'(MAX_BUSY - 1));
  assign malu_flush = resetn && (state == BUSY) && (req_kill || malu_ready || timeout);
  assign dbg_state  = state;

  // req and rsp are valid/ready channels: a transfer happens on a rising edge where
  // both are high, and the payload is held unchanged while valid waits for ready.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      malu_valid <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_hi     <= 1'b0;
      rsp_err    <= 1'b0;
      malu_rs1   <= '0;
      malu_rs2   <= '0;
      malu_rs3   <= '0;
      {malu_uop_div, malu_uop_rem, malu_uop_mul, malu_uop_madd,
       malu_uop_msub_1, malu_uop_msub_2, malu_uop_macc_1, malu_uop_macc_2} <= '0;
      {malu_mod_lh_sign, malu_mod_rh_sign, malu_mod_carryless} <= '0;
      {malu_pw_32, malu_pw_16, malu_pw_8, malu_pw_4, malu_pw_2} <= '0;
      busy_cnt   <= '0;
      wide_q     <= 1'b0;
      res_hi     <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            malu_rs1  <= req_rs1;
            malu_rs2  <= req_rs2;
            malu_rs3  <= req_rs3;
            {malu_uop_div, malu_uop_rem, malu_uop_mul, malu_uop_madd,
             malu_uop_msub_1, malu_uop_msub_2, malu_uop_macc_1, malu_uop_macc_2} <= dec_uop;
            {malu_mod_lh_sign, malu_mod_rh_sign, malu_mod_carryless} <= {dec_lh, dec_rh, dec_cl};
            {malu_pw_32, malu_pw_16, malu_pw_8, malu_pw_4, malu_pw_2} <= dec_pw;
            wide_q    <= req_wide;
            busy_cnt  <= '0;
            if (dec_legal) begin
              state      <= BUSY;
              malu_valid <= 1'b1;
            end else begin
              state     <= RSP_LO;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_hi    <= 1'b0;
              rsp_data  <= '0;
            end
          end
        end
        BUSY: begin
          if (req_kill) begin
            state      <= IDLE;
            malu_valid <= 1'b0;
            req_ready  <= 1'b1;
          end else if (malu_ready) begin
            state      <= RSP_LO;
            malu_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_hi     <= 1'b0;
            rsp_data   <= malu_result[31:0];
            res_hi     <= malu_result[63:32];
          end else if (timeout) begin
            state      <= RSP_LO;
            malu_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_hi     <= 1'b0;
            rsp_data   <= '0;
          end else if (busy_cnt != CW'(MAX_BUSY)) begin
            busy_cnt <= busy_cnt + CW'(1);
          end
        end
        RSP_LO: begin
          if (rsp_ready) begin
            if (wide_q && !rsp_err) begin
              state    <= RSP_HI;
              rsp_data <= res_hi;
              rsp_hi   <= 1'b1;
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
              rsp_data  <= '0;
              rsp_err   <= 1'b0;
              req_ready <= 1'b1;
            end
          end
        end
        RSP_HI: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hi    <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
